// File: rtl/mfp_ahb_intc.sv
// AHB-Lite interrupt controller: edge-latched pending bits, per-source mask, claim/EOI handshake.
// Define MFP_INTC_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module mfp_ahb_intc #(
    parameter int unsigned N_SRC = 2
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [3:0]       HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    input  logic             HSEL,
    output logic [31:0]      HRDATA,
    input  logic [N_SRC-1:0] SRC_INT,
    output logic             IRQ,
    output logic [3:0]       IRQ_ID
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [3:0]       haddr_d;
    logic [1:0]       htrans_d;
    logic             hwrite_d, hsel_d;
    logic [N_SRC-1:0] src_d, pend, mask, elig, rise, w1c, id_onehot;
    logic             we, rd_acc, claim, eoi_hit, win_valid, cur_elig, irq_n;
    logic [3:0]       winner;
    logic [31:0]      rd_data;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            haddr_d  <= '0;
            htrans_d <= '0;
            hwrite_d <= 1'b0;
            hsel_d   <= 1'b0;
        end else begin
            haddr_d  <= HADDR;
            htrans_d <= HTRANS;
            hwrite_d <= HWRITE;
            hsel_d   <= HSEL;
        end
    end

    assign we     = hsel_d & hwrite_d & (htrans_d != 2'b00);
    assign rd_acc = HSEL & ~HWRITE & (HTRANS != 2'b00);
    assign rise   = SRC_INT & ~src_d;
    assign elig   = pend & mask;
    assign w1c    = (we && haddr_d == 4'd0) ? HWDATA[N_SRC-1:0] : '0;

`ifdef MFP_INTC_RR_EN
    logic [3:0] last_id;

    // Search starts just past the last claimed ID and wraps modulo N_SRC.
    always_comb begin
        int unsigned idx;
        winner    = '0;
        win_valid = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            idx = 32'(last_id) + 1 + i;
            if (idx >= N_SRC) idx = idx - N_SRC;
            for (int unsigned j = 0; j < N_SRC; j++) begin
                if (!win_valid && j == idx && elig[j]) begin
                    winner    = 4'(j);
                    win_valid = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)     last_id <= '0;
        else if (claim) last_id <= IRQ_ID;
    end
`else
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!win_valid && elig[i]) begin
                winner    = 4'(i);
                win_valid = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        cur_elig  = 1'b0;
        id_onehot = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (IRQ_ID == 4'(i)) begin
                cur_elig     = elig[i];
                id_onehot[i] = 1'b1;
            end
        end
    end

    assign claim   = rd_acc && (HADDR == 4'd2) && (state == ST_REQ) && cur_elig;
    assign eoi_hit = we && (haddr_d == 4'd3) && (HWDATA[3:0] == IRQ_ID);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Losing eligibility (W1C or mask drop) withdraws the request ahead of a claim.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (win_valid) state_n = ST_REQ;
            ST_REQ: begin
                if (!cur_elig)  state_n = ST_IDLE;
                else if (claim) state_n = ST_SERV;
            end
            ST_SERV: if (eoi_hit) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        irq_n = (state_n == ST_REQ);
        case (HADDR)
            4'd0:    rd_data = 32'(pend);
            4'd1:    rd_data = 32'(mask);
            4'd2:    rd_data = claim ? {1'b1, 27'b0, IRQ_ID} : '0;
            4'd4:    rd_data = {30'b0, state};
            default: rd_data = '0;
        endcase
    end

    // A new edge wins over both W1C and the claim clear on the same bit.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            src_d  <= '0;
            pend   <= '0;
            mask   <= '0;
            HRDATA <= '0;
            IRQ    <= 1'b0;
            IRQ_ID <= '0;
        end else begin
            src_d <= SRC_INT;
            pend  <= (pend & ~w1c & ~(claim ? id_onehot : '0)) | rise;
            if (we && haddr_d == 4'd1) mask <= HWDATA[N_SRC-1:0];
            if (rd_acc) HRDATA <= rd_data;
            IRQ <= irq_n;
            if (state == ST_IDLE && win_valid) IRQ_ID <= winner;
        end
    end

endmodule

// File: tb/tb_mfp_ahb_intc.sv
// Directed bench for mfp_ahb_intc: register table plus claim/EOI, mask, collision and reset sequences.
module tb_mfp_ahb_intc;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [3:0]  HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        HSEL = 1'b0;
    logic [31:0] HRDATA;
    logic [1:0]  SRC_INT = '0;
    logic        IRQ;
    logic [3:0]  IRQ_ID;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic [31:0] rd;

`ifdef MFP_INTC_RR_EN
    localparam logic [3:0] FIRST_ID  = 4'd1;
    localparam logic [3:0] SECOND_ID = 4'd0;
`else
    localparam logic [3:0] FIRST_ID  = 4'd0;
    localparam logic [3:0] SECOND_ID = 4'd1;
`endif

    mfp_ahb_intc #(.N_SRC(2)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HSEL(HSEL), .HRDATA(HRDATA),
        .SRC_INT(SRC_INT), .IRQ(IRQ), .IRQ_ID(IRQ_ID)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        HADDR = a; HWRITE = 1'b1; HSEL = 1'b1; HTRANS = 2'b10;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(negedge HCLK);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        HADDR = a; HWRITE = 1'b0; HSEL = 1'b1; HTRANS = 2'b10;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
    endtask

    task automatic do_reset();
        SRC_INT = '0; HSEL = 1'b0; HTRANS = 2'b00;
        HRESET = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
    endtask

    task automatic pulse(input logic [1:0] s);
        SRC_INT = s;
        @(negedge HCLK);
        SRC_INT = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd1, 32'hFFFF_FFFF, 4'd1, 32'h3};
        vecs[1] = '{4'd1, 32'h0,         4'd1, 32'h0};
        vecs[2] = '{4'd1, 32'h2,         4'd1, 32'h2};
        vecs[3] = '{4'd7, 32'hFFFF_FFFF, 4'd1, 32'h2};
        vecs[4] = '{4'd1, 32'h1,         4'd7, 32'h0};
        vecs[5] = '{4'd5, 32'h1,         4'd4, 32'h0};
        vecs[6] = '{4'd0, 32'hFFFF,      4'd0, 32'h0};
        vecs[7] = '{4'd1, 32'hFFFF_FFFC, 4'd1, 32'h0};

        // reset state
        @(negedge HCLK);
        check("rst_irq", 32'(IRQ), 32'h0);
        check("rst_hrdata", HRDATA, 32'h0);
        HRESET = 1'b0;
        @(negedge HCLK);
        bus_read(4'd0, rd); check("rst_pend", rd, 32'h0);
        bus_read(4'd1, rd); check("rst_mask", rd, 32'h0);
        bus_read(4'd4, rd); check("rst_status", rd, 32'h0);

        for (int i = 0; i < 8; i++) begin
            bus_write(vecs[i].waddr, vecs[i].wdata);
            bus_read(vecs[i].raddr, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // basic claim
        do_reset();
        bus_write(4'd1, 32'h3);
        pulse(2'b10);
        check("basic_irq_k1", 32'(IRQ), 32'h0);
        @(negedge HCLK);
        check("basic_irq", 32'(IRQ), 32'h1);
        check("basic_id", 32'(IRQ_ID), 32'h1);
        bus_read(4'd2, rd);
        check("basic_claim", rd, 32'h8000_0001);
        check("basic_irq_off", 32'(IRQ), 32'h0);
        bus_read(4'd0, rd); check("basic_pend", rd, 32'h0);
        bus_read(4'd4, rd); check("basic_status_serv", rd, 32'h2);
        bus_write(4'd3, 32'h1);
        bus_read(4'd4, rd); check("basic_status_idle", rd, 32'h0);

        // priority with simultaneous edges
        do_reset();
        bus_write(4'd1, 32'h3);
        pulse(2'b11);
        @(negedge HCLK);
        check("prio_irq", 32'(IRQ), 32'h1);
        check("prio_id1", 32'(IRQ_ID), 32'(FIRST_ID));
        bus_read(4'd2, rd);
        check("prio_claim1", rd, {1'b1, 27'b0, FIRST_ID});
        bus_write(4'd3, 32'(FIRST_ID));
        @(negedge HCLK);
        check("prio_irq2", 32'(IRQ), 32'h1);
        check("prio_id2", 32'(IRQ_ID), 32'(SECOND_ID));
        bus_read(4'd2, rd);
        check("prio_claim2", rd, {1'b1, 27'b0, SECOND_ID});
        bus_write(4'd3, 32'(SECOND_ID));
        bus_read(4'd0, rd); check("prio_pend", rd, 32'h0);

        // mask gating
        do_reset();
        pulse(2'b01);
        @(negedge HCLK);
        bus_read(4'd0, rd); check("mask_pend", rd, 32'h1);
        check("mask_irq_off", 32'(IRQ), 32'h0);
        bus_write(4'd1, 32'h1);
        @(negedge HCLK);
        check("mask_irq_on", 32'(IRQ), 32'h1);
        bus_write(4'd1, 32'h0);
        @(negedge HCLK);
        check("mask_drop_irq", 32'(IRQ), 32'h0);
        bus_read(4'd4, rd); check("mask_drop_status", rd, 32'h0);

        // set beats W1C on the same bit
        do_reset();
        pulse(2'b01);
        @(negedge HCLK);
        HADDR = 4'd0; HWRITE = 1'b1; HSEL = 1'b1; HTRANS = 2'b10;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h1; SRC_INT = 2'b01;
        @(negedge HCLK);
        SRC_INT = '0;
        bus_read(4'd0, rd); check("coll_pend", rd, 32'h1);
        bus_write(4'd0, 32'h1);
        bus_read(4'd0, rd); check("w1c_pend", rd, 32'h0);

        // handshake errors
        do_reset();
        bus_read(4'd2, rd); check("idle_claim", rd, 32'h0);
        bus_write(4'd1, 32'h3);
        pulse(2'b01);
        @(negedge HCLK);
        check("hs_irq", 32'(IRQ), 32'h1);
        bus_read(4'd2, rd); check("hs_claim", rd, 32'h8000_0000);
        bus_write(4'd3, 32'h5);
        bus_read(4'd4, rd); check("hs_bad_eoi", rd, 32'h2);
        bus_read(4'd2, rd); check("serv_claim", rd, 32'h0);
        bus_read(4'd4, rd); check("serv_status", rd, 32'h2);
        pulse(2'b10);
        @(negedge HCLK);
        check("serv_irq", 32'(IRQ), 32'h0);
        bus_read(4'd0, rd); check("serv_pend", rd, 32'h2);
        bus_write(4'd3, 32'h0);
        @(negedge HCLK);
        check("hs_reirq", 32'(IRQ), 32'h1);
        check("hs_reid", 32'(IRQ_ID), 32'h1);

        // asynchronous reset mid-SERV
        bus_read(4'd2, rd); check("ar_claim", rd, 32'h8000_0001);
        pulse(2'b01);
        @(negedge HCLK);
        #2 HRESET = 1'b1;
        #1;
        check("ar_irq", 32'(IRQ), 32'h0);
        check("ar_id", 32'(IRQ_ID), 32'h0);
        check("ar_hrdata", HRDATA, 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        bus_read(4'd0, rd); check("ar_pend", rd, 32'h0);
        bus_read(4'd1, rd); check("ar_mask", rd, 32'h0);
        bus_read(4'd4, rd); check("ar_status", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
